id_operand_stage: RTL and testbench

Decode-side operand stage of the 5-stage MIPS pipeline, directly upstream of the register file read ports and directly downstream of the IF/ID register. It drives the two regfile read ports and resolves EX/MEM data hazards by forwarding. It detects load-use hazards and inserts a one-cycle bubble, then captures the resolved operands into the ID/EX pipeline register. Write-back-to-read bypass is already done inside the register file, so this block forwards only from EX and MEM.

---
 rtl/id_operand_stage.sv | 111 +++++++++++
 tb/tb_id_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode-side operand stage: drives the regfile read ports, forwards from EX/MEM,
// inserts a one-cycle bubble on load-use hazards and registers operands into ID/EX.
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [ADDR_W-1:0]  id_rs_addr,
    input  logic [ADDR_W-1:0]  id_rt_addr,
    input  logic               id_rs_re,
    input  logic               id_rt_re,
    input  logic [ADDR_W-1:0]  id_waddr,
    input  logic               id_we,
    input  logic               id_is_load,
    input  logic [ALUOP_W-1:0] id_aluop,
    output logic               rf_re1,
    output logic               rf_re2,
    output logic [ADDR_W-1:0]  rf_raddr1,
    output logic [ADDR_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic [DATA_W-1:0]  ex_fwd_wdata,
    input  logic               mem_we,
    input  logic [ADDR_W-1:0]  mem_waddr,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               ex_hold,
    input  logic               flush,
    output logic               ex_valid_o,
    output logic               ex_we_o,
    output logic               ex_is_load_o,
    output logic [ADDR_W-1:0]  ex_waddr_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic [DATA_W-1:0]  ex_opnd1_o,
    output logic [DATA_W-1:0]  ex_opnd2_o,
    output logic               id_stall,
    output logic [CNT_W-1:0]   load_use_cnt
);

    logic              ex_fwd_ok;
    logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic              lu;
    logic [DATA_W-1:0] opnd1, opnd2;

    assign rf_re1    = id_valid & id_rs_re;
    assign rf_re2    = id_valid & id_rt_re;
    assign rf_raddr1 = id_rs_addr;
    assign rf_raddr2 = id_rt_addr;

    // A load in EX has no data yet, so only non-load producers may forward from EX.
    assign ex_fwd_ok = ex_valid_o & ex_we_o & ~ex_is_load_o;
    assign ex_hit1   = ex_fwd_ok & (ex_waddr_o == id_rs_addr);
    assign ex_hit2   = ex_fwd_ok & (ex_waddr_o == id_rt_addr);
    assign mem_hit1  = mem_we & (mem_waddr == id_rs_addr);
    assign mem_hit2  = mem_we & (mem_waddr == id_rt_addr);

    assign opnd1 = (!id_rs_re || id_rs_addr == '0) ? '0 :
                   ex_hit1  ? ex_fwd_wdata :
                   mem_hit1 ? mem_wdata    : rf_rdata1;
    assign opnd2 = (!id_rt_re || id_rt_addr == '0) ? '0 :
                   ex_hit2  ? ex_fwd_wdata :
                   mem_hit2 ? mem_wdata    : rf_rdata2;

    assign lu = id_valid & ex_valid_o & ex_we_o & ex_is_load_o & (ex_waddr_o != '0) &
                ((id_rs_re & (ex_waddr_o == id_rs_addr)) |
                 (id_rt_re & (ex_waddr_o == id_rt_addr)));

    assign id_stall = rst & ~flush & (ex_hold | lu);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_o   <= 1'b0;
            ex_we_o      <= 1'b0;
            ex_is_load_o <= 1'b0;
            ex_waddr_o   <= '0;
            ex_aluop_o   <= '0;
            ex_opnd1_o   <= '0;
            ex_opnd2_o   <= '0;
            load_use_cnt <= '0;
        end else if (flush) begin
            ex_valid_o   <= 1'b0;
            ex_we_o      <= 1'b0;
            ex_is_load_o <= 1'b0;
            ex_waddr_o   <= '0;
            ex_aluop_o   <= '0;
            ex_opnd1_o   <= '0;
            ex_opnd2_o   <= '0;
        end else if (ex_hold) begin
            // EX busy: ID/EX keeps its contents, a pending lu is re-evaluated later.
        end else if (lu) begin
            ex_valid_o   <= 1'b0;
            ex_we_o      <= 1'b0;
            ex_is_load_o <= 1'b0;
            if (load_use_cnt != '1)
                load_use_cnt <= load_use_cnt + 1'b1;
        end else begin
            ex_valid_o   <= id_valid;
            ex_we_o      <= id_we & id_valid;
            ex_is_load_o <= id_is_load;
            ex_waddr_o   <= id_waddr;
            ex_aluop_o   <= id_aluop;
            ex_opnd1_o   <= opnd1;
            ex_opnd2_o   <= opnd2;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: a behavioural ID/EX model checked every cycle,
// plus literal expectations for the forwarding, load-use, hold/flush and saturation cases.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_re, id_rt_re, id_we, id_is_load;
    logic [4:0]  id_rs_addr, id_rt_addr, id_waddr;
    logic [7:0]  id_aluop;
    logic        rf_re1, rf_re2;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] ex_fwd_wdata, mem_wdata;
    logic        mem_we, ex_hold, flush;
    logic [4:0]  mem_waddr;
    logic        ex_valid_o, ex_we_o, ex_is_load_o, id_stall;
    logic [4:0]  ex_waddr_o;
    logic [7:0]  ex_aluop_o;
    logic [31:0] ex_opnd1_o, ex_opnd2_o;
    logic [15:0] load_use_cnt;

    // Second instance with a 2-bit counter so saturation is reachable in a few events.
    logic        s_re1, s_re2, s_valid, s_we, s_load, s_stall;
    logic [4:0]  s_raddr1, s_raddr2, s_waddr;
    logic [7:0]  s_aluop;
    logic [31:0] s_op1, s_op2;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Regfile contents are a recognisable function of the register number.
    assign rf_rdata1 = 32'hF000_0000 | 32'(rf_raddr1);
    assign rf_rdata2 = 32'hF000_0000 | 32'(rf_raddr2);

    id_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .id_waddr(id_waddr), .id_we(id_we), .id_is_load(id_is_load), .id_aluop(id_aluop),
        .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_fwd_wdata(ex_fwd_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ex_hold(ex_hold), .flush(flush),
        .ex_valid_o(ex_valid_o), .ex_we_o(ex_we_o), .ex_is_load_o(ex_is_load_o),
        .ex_waddr_o(ex_waddr_o), .ex_aluop_o(ex_aluop_o),
        .ex_opnd1_o(ex_opnd1_o), .ex_opnd2_o(ex_opnd2_o),
        .id_stall(id_stall), .load_use_cnt(load_use_cnt)
    );

    id_operand_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .id_waddr(id_waddr), .id_we(id_we), .id_is_load(id_is_load), .id_aluop(id_aluop),
        .rf_re1(s_re1), .rf_re2(s_re2), .rf_raddr1(s_raddr1), .rf_raddr2(s_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_fwd_wdata(ex_fwd_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ex_hold(ex_hold), .flush(flush),
        .ex_valid_o(s_valid), .ex_we_o(s_we), .ex_is_load_o(s_load),
        .ex_waddr_o(s_waddr), .ex_aluop_o(s_aluop),
        .ex_opnd1_o(s_op1), .ex_opnd2_o(s_op2),
        .id_stall(s_stall), .load_use_cnt(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         model_live = 0;
    bit         m_valid = 0, m_we = 0, m_load = 0;
    bit [4:0]   m_waddr = 0;
    bit [7:0]   m_aluop = 0;
    bit [31:0]  m_op1 = 0, m_op2 = 0;
    int         m_cnt = 0;

    function automatic bit [31:0] model_opnd(bit re, bit [4:0] a, bit [31:0] rf);
        if (!re || a == 0)                             return 0;
        if (m_valid && m_we && !m_load && m_waddr == a) return ex_fwd_wdata;
        if (mem_we && mem_waddr == a)                  return mem_wdata;
        return rf;
    endfunction

    function automatic bit model_lu();
        bit uses = (id_rs_re && id_rs_addr == m_waddr) || (id_rt_re && id_rt_addr == m_waddr);
        return id_valid && m_valid && m_we && m_load && m_waddr != 0 && uses;
    endfunction

    function automatic bit model_stall();
        return rst && !flush && (ex_hold || model_lu());
    endfunction

    always @(posedge clk) begin
        model_live <= 1;
        if (!rst) begin
            {m_valid, m_we, m_load, m_waddr, m_aluop, m_op1, m_op2} <= '0;
            m_cnt <= 0;
        end else if (flush) begin
            {m_valid, m_we, m_load, m_waddr, m_aluop, m_op1, m_op2} <= '0;
        end else if (ex_hold) begin
            m_cnt <= m_cnt;
        end else if (model_lu()) begin
            m_valid <= 0;
            m_we    <= 0;
            m_load  <= 0;
            m_cnt   <= m_cnt + 1;
        end else begin
            m_valid <= id_valid;
            m_we    <= id_we && id_valid;
            m_load  <= id_is_load;
            m_waddr <= id_waddr;
            m_aluop <= id_aluop;
            m_op1   <= model_opnd(id_rs_re, id_rs_addr, rf_rdata1);
            m_op2   <= model_opnd(id_rt_re, id_rt_addr, rf_rdata2);
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("m_valid",  32'(ex_valid_o),   32'(m_valid));
            check("m_we",     32'(ex_we_o),      32'(m_we));
            check("m_load",   32'(ex_is_load_o), 32'(m_load));
            check("m_waddr",  32'(ex_waddr_o),   32'(m_waddr));
            check("m_aluop",  32'(ex_aluop_o),   32'(m_aluop));
            check("m_opnd1",  ex_opnd1_o,        m_op1);
            check("m_opnd2",  ex_opnd2_o,        m_op2);
            check("m_stall",  32'(id_stall),     32'(model_stall()));
            check("m_cnt",    32'(load_use_cnt), (m_cnt > 65535) ? 32'hFFFF : 32'(m_cnt));
            check("m_cnt_sat", 32'(s_cnt),       (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
            check("m_re1",    32'(rf_re1),       32'(id_valid && id_rs_re));
            check("m_re2",    32'(rf_re2),       32'(id_valid && id_rt_re));
            check("m_raddr1", 32'(rf_raddr1),    32'(id_rs_addr));
            check("m_raddr2", 32'(rf_raddr2),    32'(id_rt_addr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input bit v, input bit [4:0] rs, input bit rs_re,
                             input bit [4:0] rt, input bit rt_re, input bit [4:0] wa,
                             input bit we, input bit ld, input bit [7:0] op);
        id_valid = v;  id_rs_addr = rs; id_rs_re = rs_re;
        id_rt_addr = rt; id_rt_re = rt_re; id_waddr = wa;
        id_we = we; id_is_load = ld; id_aluop = op;
    endtask

    initial begin
        rst = 0; ex_hold = 1; flush = 0; mem_we = 0; mem_waddr = 0;
        mem_wdata = 0; ex_fwd_wdata = 0;
        set_instr(1, 1, 1, 2, 1, 3, 1, 0, 8'h21);

        // Reset held two cycles with a valid instruction and hold asserted.
        tick(); tick();
        check("rst_stall", 32'(id_stall), 32'd0);
        check("rst_valid", 32'(ex_valid_o), 32'd0);
        check("rst_opnd1", ex_opnd1_o, 32'd0);
        check("rst_cnt", 32'(load_use_cnt), 32'd0);
        rst = 1; ex_hold = 0;

        // EX forwarding: addu $3 captured, then a reader of $3 and of $0.
        tick();
        ex_fwd_wdata = 32'h1234; mem_we = 1; mem_waddr = 0; mem_wdata = 32'hFFFF;
        set_instr(1, 3, 1, 0, 1, 9, 1, 0, 8'h21);
        #1 check("exfwd_stall", 32'(id_stall), 32'd0);
        tick();
        check("exfwd_opnd1", ex_opnd1_o, 32'h0000_1234);
        check("zero_opnd2", ex_opnd2_o, 32'd0);

        // EX beats MEM for the same destination; MEM used once EX no longer matches.
        mem_we = 0;
        set_instr(1, 1, 1, 2, 1, 5, 1, 0, 8'h21);
        tick();
        ex_fwd_wdata = 32'hA; mem_we = 1; mem_waddr = 5; mem_wdata = 32'hB;
        set_instr(1, 5, 1, 5, 1, 10, 1, 0, 8'h21);
        tick();
        check("prio_opnd1", ex_opnd1_o, 32'hA);
        check("prio_opnd2", ex_opnd2_o, 32'hA);
        tick();
        check("memfwd_opnd1", ex_opnd1_o, 32'hB);
        check("rf_opnd1", 32'(mem_we), 32'd1);

        // Load-use: lw $4 then a reader of $4 -> one bubble, then MEM forwarding.
        mem_we = 0;
        set_instr(1, 1, 1, 2, 1, 4, 1, 1, 8'h23);
        tick();
        ex_fwd_wdata = 32'h5555;
        set_instr(1, 0, 0, 4, 1, 11, 1, 0, 8'h21);
        #1 check("lu_stall", 32'(id_stall), 32'd1);
        tick();
        check("lu_bubble", 32'(ex_valid_o), 32'd0);
        check("lu_cnt", 32'(load_use_cnt), 32'd1);
        mem_we = 1; mem_waddr = 4; mem_wdata = 32'hDEAD_BEEF;
        #1 check("lu_nostall", 32'(id_stall), 32'd0);
        tick();
        check("lu_opnd2", ex_opnd2_o, 32'hDEAD_BEEF);
        check("lu_valid", 32'(ex_valid_o), 32'd1);

        // Hold for three cycles, then flush together with hold.
        mem_we = 0;
        set_instr(1, 1, 1, 2, 1, 7, 1, 0, 8'h55);
        tick();
        ex_hold = 1;
        set_instr(1, 3, 1, 3, 1, 8, 1, 0, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", 32'(id_stall), 32'd1);
            tick();
            check("hold_aluop", 32'(ex_aluop_o), 32'h55);
            check("hold_waddr", 32'(ex_waddr_o), 32'd7);
        end
        flush = 1;
        #1 check("flush_stall", 32'(id_stall), 32'd0);
        tick();
        check("flush_valid", 32'(ex_valid_o), 32'd0);
        check("flush_we", 32'(ex_we_o), 32'd0);
        flush = 0; ex_hold = 0;

        // Hold coinciding with load-use: no count until hold drops.
        set_instr(1, 1, 1, 2, 1, 6, 1, 1, 8'h23);
        tick();
        set_instr(1, 6, 1, 0, 0, 12, 1, 0, 8'h21);
        ex_hold = 1;
        #1 check("holdlu_stall", 32'(id_stall), 32'd1);
        tick();
        check("holdlu_cnt", 32'(load_use_cnt), 32'd1);
        check("holdlu_load", 32'(ex_is_load_o), 32'd1);
        ex_hold = 0;
        #1 check("holdlu_relu", 32'(id_stall), 32'd1);
        tick();
        check("holdlu_cnt2", 32'(load_use_cnt), 32'd2);
        tick();

        // Load with a dependent two slots later: no stall, MEM forwarding.
        set_instr(1, 1, 1, 2, 1, 13, 1, 1, 8'h23);
        tick();
        set_instr(1, 1, 1, 2, 1, 14, 1, 0, 8'h21);
        #1 check("gap_stall1", 32'(id_stall), 32'd0);
        tick();
        mem_we = 1; mem_waddr = 13; mem_wdata = 32'h0BAD_F00D;
        set_instr(1, 13, 1, 0, 0, 15, 1, 0, 8'h21);
        #1 check("gap_stall2", 32'(id_stall), 32'd0);
        tick();
        check("gap_opnd1", ex_opnd1_o, 32'h0BAD_F00D);
        mem_we = 0;

        // Reset asserted in the middle of a load-use stall.
        set_instr(1, 1, 1, 2, 1, 6, 1, 1, 8'h23);
        tick();
        set_instr(1, 6, 1, 0, 0, 12, 1, 0, 8'h21);
        #1 check("midrst_pre", 32'(id_stall), 32'd1);
        rst = 0;
        #1 check("midrst_stall", 32'(id_stall), 32'd0);
        tick();
        check("midrst_cnt", 32'(load_use_cnt), 32'd0);
        check("midrst_load", 32'(ex_is_load_o), 32'd0);
        rst = 1;

        // Four load-use events: 16-bit counter reaches 4, 2-bit counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            set_instr(1, 1, 1, 3, 1, 2, 1, 1, 8'h23);
            tick();
            set_instr(1, 2, 1, 0, 0, 16, 1, 0, 8'h21);
            tick();
            tick();
        end
        check("sat_cnt16", 32'(load_use_cnt), 32'd4);
        check("sat_cnt2", 32'(s_cnt), 32'd3);

        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
